// File: rtl/imul_sign_sequencer_if.sv
// Handshake and datapath bundle for imul_sign_sequencer.
// slave  : the sequencer itself (takes requests and the array product, drives results).
// master : the requester side plus the array multiplier's product output.
interface imul_sign_sequencer_if;
    logic        iStart;
    logic        iSigned;
    logic [15:0] iA;
    logic [15:0] iB;
    logic [15:0] oMagA;
    logic [15:0] oMagB;
    logic [31:0] iProd;
    logic [31:0] oResult;
    logic        oDone;
    logic        oBusy;

    modport slave (
        input  iStart, iSigned, iA, iB, iProd,
        output oMagA, oMagB, oResult, oDone, oBusy
    );

    modport master (
        output iStart, iSigned, iA, iB, iProd,
        input  oMagA, oMagB, oResult, oDone, oBusy
    );
endinterface

// File: rtl/imul_sign_sequencer.sv
// Sign-handling sequencer wrapped around an external 16x16 unsigned ripple array multiplier.
// Operands are reduced to magnitudes, the array is given SETTLE_CYCLES to settle, and the
// captured product is negated when exactly one signed operand was negative.
// Optional build macro IMUL_ZERO_SKIP_EN: a zero operand bypasses the settle wait and
// forces a zero result.
module imul_sign_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic                  Clock,
    input  logic                  Reset,
    imul_sign_sequencer_if.slave  bus
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWait    = 2'd1;
    localparam logic [1:0] StCapture = 2'd2;

    localparam logic [3:0] CntInit = 4'(SETTLE_CYCLES - 1);

    logic [1:0]  state_q,  state_d;
    logic [3:0]  cnt_q,    cnt_d;
    logic        sign_q,   sign_d;
    logic [15:0] mag_a_q,  mag_a_d;
    logic [15:0] mag_b_q,  mag_b_d;
    logic [31:0] result_q, result_d;
    logic        done_q,   done_d;
    logic        busy_q,   busy_d;
`ifdef IMUL_ZERO_SKIP_EN
    logic        zero_q,   zero_d;
`endif

    // Next-state logic: accept in idle, count down the settle window, then sign-correct.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        result_d = result_q;
        done_d   = 1'b0;
        busy_d   = busy_q;
`ifdef IMUL_ZERO_SKIP_EN
        zero_d   = zero_q;
`endif
        case (state_q)
            StIdle: begin
                if (bus.iStart) begin
                    sign_d  = bus.iSigned & (bus.iA[15] ^ bus.iB[15]);
                    // -32768 maps to 0x8000, which the unsigned array handles exactly
                    mag_a_d = (bus.iSigned & bus.iA[15]) ? 16'(~bus.iA + 16'd1) : bus.iA;
                    mag_b_d = (bus.iSigned & bus.iB[15]) ? 16'(~bus.iB + 16'd1) : bus.iB;
                    cnt_d   = CntInit;
                    busy_d  = 1'b1;
`ifdef IMUL_ZERO_SKIP_EN
                    zero_d  = (bus.iA == 16'd0) || (bus.iB == 16'd0);
                    state_d = zero_d ? StCapture : StWait;
`else
                    state_d = StWait;
`endif
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StCapture;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StCapture: begin
                // Negating a zero product yields zero, so no special case is needed here
                result_d = sign_q ? (~bus.iProd + 32'd1) : bus.iProd;
`ifdef IMUL_ZERO_SKIP_EN
                // The array has not settled on the skip path, so ignore its output
                if (zero_q) begin
                    result_d = 32'd0;
                end
`endif
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            sign_q   <= 1'b0;
            mag_a_q  <= 16'd0;
            mag_b_q  <= 16'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
`ifdef IMUL_ZERO_SKIP_EN
            zero_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef IMUL_ZERO_SKIP_EN
            zero_q   <= zero_d;
`endif
        end
    end

    assign bus.oMagA   = mag_a_q;
    assign bus.oMagB   = mag_b_q;
    assign bus.oResult = result_q;
    assign bus.oDone   = done_q;
    assign bus.oBusy   = busy_q;

endmodule

// File: tb/tb_imul_sign_sequencer.sv
// Directed bench for imul_sign_sequencer with SETTLE_CYCLES=2 and a behavioural
// unsigned array multiplier between the magnitude outputs and the product input.
module tb_imul_sign_sequencer;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    imul_sign_sequencer_if bus ();

    // Behavioural stand-in for the unsigned array multiplier
    assign bus.iProd = 32'(bus.oMagA) * 32'(bus.oMagB);

    imul_sign_sequencer #(.SETTLE_CYCLES(2)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clock = ~Clock;

    // Issues one operation and watches it; lat = edges from acceptance to oDone (99 on timeout).
    task automatic run_op(input logic sgn, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output int busy_n, output logic [15:0] ma,
                          output logic [15:0] mb, output logic again);
        @(negedge Clock);
        bus.iSigned = sgn;
        bus.iA      = a;
        bus.iB      = b;
        bus.iStart  = 1'b1;
        @(posedge Clock);
        #1;
        bus.iStart  = 1'b0;
        bus.iA      = ~a;
        bus.iB      = ~b;
        bus.iSigned = ~sgn;
        lat = 99; busy_n = 0; ma = '0; mb = '0; again = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            @(negedge Clock);
            if (e == 0) begin
                ma = bus.oMagA;
                mb = bus.oMagB;
            end
            if (bus.oBusy) busy_n++;
            if (bus.oDone) begin
                lat = e;
                @(negedge Clock);
                again = bus.oDone;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.iStart = 1'b0; bus.iSigned = 1'b0; bus.iA = 16'h1234; bus.iB = 16'h5678;
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        n_cmp++;
        if (bus.oMagA !== 16'd0 || bus.oMagB !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_mag: got %h/%h expected 0000/0000", bus.oMagA, bus.oMagB);
        end
        n_cmp++;
        if (bus.oResult !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_result: got %h expected 00000000", bus.oResult);
        end
        n_cmp++;
        if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got done=%b busy=%b expected 0/0", bus.oDone, bus.oBusy);
        end
        // Start while reset is held must not be accepted
        bus.iStart = 1'b1;
        @(negedge Clock);
        n_cmp++;
        if (bus.oBusy !== 1'b0 || bus.oMagA !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_priority: got busy=%b magA=%h expected 0/0000",
                     bus.oBusy, bus.oMagA);
        end
        bus.iStart = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_unsigned_max();
        int lat, busy_n; logic [15:0] ma, mb; logic again;
        run_op(1'b0, 16'hFFFF, 16'hFFFF, lat, busy_n, ma, mb, again);
        n_cmp++;
        if (ma !== 16'hFFFF || mb !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL umax_mag: got %h/%h expected ffff/ffff", ma, mb);
        end
        n_cmp++;
        if (bus.oResult !== 32'hFFFE0001) begin
            n_bad++;
            $display("FAIL umax_result: got %h expected fffe0001", bus.oResult);
        end
        n_cmp++;
        if (lat !== 3) begin
            n_bad++;
            $display("FAIL umax_latency: got %0d expected 3", lat);
        end
        n_cmp++;
        if (busy_n !== 3) begin
            n_bad++;
            $display("FAIL umax_busy_cycles: got %0d expected 3", busy_n);
        end
        n_cmp++;
        if (again !== 1'b0) begin
            n_bad++;
            $display("FAIL umax_done_width: got done=%b after pulse expected 0", again);
        end
    endtask

    task automatic test_signed();
        int lat, busy_n; logic [15:0] ma, mb; logic again;
        run_op(1'b1, 16'hFFFD, 16'd5, lat, busy_n, ma, mb, again);
        n_cmp++;
        if (ma !== 16'd3 || mb !== 16'd5) begin
            n_bad++;
            $display("FAIL sneg_mag: got %h/%h expected 0003/0005", ma, mb);
        end
        n_cmp++;
        if (bus.oResult !== 32'hFFFFFFF1) begin
            n_bad++;
            $display("FAIL sneg_result: got %h expected fffffff1", bus.oResult);
        end
        run_op(1'b1, 16'h8000, 16'h8000, lat, busy_n, ma, mb, again);
        n_cmp++;
        if (ma !== 16'h8000 || mb !== 16'h8000) begin
            n_bad++;
            $display("FAIL smin_mag: got %h/%h expected 8000/8000", ma, mb);
        end
        n_cmp++;
        if (bus.oResult !== 32'h40000000 || lat !== 3) begin
            n_bad++;
            $display("FAIL smin_result: got %h lat %0d expected 40000000 lat 3",
                     bus.oResult, lat);
        end
    endtask

    task automatic test_zero();
        int lat, busy_n, exp_lat; logic [15:0] ma, mb; logic again;
`ifdef IMUL_ZERO_SKIP_EN
        exp_lat = 1;
`else
        exp_lat = 3;
`endif
        run_op(1'b1, 16'd0, 16'hFFF9, lat, busy_n, ma, mb, again);
        n_cmp++;
        if (ma !== 16'd0 || mb !== 16'd7) begin
            n_bad++;
            $display("FAIL zero_mag: got %h/%h expected 0000/0007", ma, mb);
        end
        n_cmp++;
        if (bus.oResult !== 32'd0) begin
            n_bad++;
            $display("FAIL zero_result: got %h expected 00000000", bus.oResult);
        end
        n_cmp++;
        if (lat !== exp_lat) begin
            n_bad++;
            $display("FAIL zero_latency: got %0d expected %0d", lat, exp_lat);
        end
    endtask

    task automatic test_start_ignored();
        int dones, first;
        @(negedge Clock);
        bus.iSigned = 1'b1; bus.iA = 16'hFFFD; bus.iB = 16'd5; bus.iStart = 1'b1;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        @(negedge Clock);
        // Second request while in the settle wait
        bus.iSigned = 1'b0; bus.iA = 16'd100; bus.iB = 16'd200; bus.iStart = 1'b1;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        dones = 0; first = 99;
        for (int e = 1; e <= 10; e++) begin
            @(negedge Clock);
            if (bus.oDone) begin
                dones++;
                if (first == 99) first = e;
            end
        end
        n_cmp++;
        if (dones !== 1) begin
            n_bad++;
            $display("FAIL ignore_done_count: got %0d expected 1", dones);
        end
        n_cmp++;
        if (first !== 3) begin
            n_bad++;
            $display("FAIL ignore_latency: got %0d expected 3", first);
        end
        n_cmp++;
        if (bus.oResult !== 32'hFFFFFFF1) begin
            n_bad++;
            $display("FAIL ignore_result: got %h expected fffffff1", bus.oResult);
        end
    endtask

    task automatic test_reset_mid();
        int dones, lat, busy_n; logic [15:0] ma, mb; logic again;
        @(negedge Clock);
        bus.iSigned = 1'b0; bus.iA = 16'h0100; bus.iB = 16'h0100; bus.iStart = 1'b1;
        @(posedge Clock);
        #1;
        bus.iStart = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock);
        n_cmp++;
        if (bus.oMagA !== 16'd0 || bus.oMagB !== 16'd0 || bus.oResult !== 32'd0) begin
            n_bad++;
            $display("FAIL midreset_data: got %h/%h/%h expected zeros",
                     bus.oMagA, bus.oMagB, bus.oResult);
        end
        n_cmp++;
        if (bus.oBusy !== 1'b0 || bus.oDone !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_flags: got busy=%b done=%b expected 0/0",
                     bus.oBusy, bus.oDone);
        end
        Reset = 1'b0;
        dones = 0;
        for (int e = 0; e < 6; e++) begin
            @(negedge Clock);
            if (bus.oDone) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL midreset_no_done: got %0d pulses expected 0", dones);
        end
        run_op(1'b0, 16'd7, 16'd9, lat, busy_n, ma, mb, again);
        n_cmp++;
        if (bus.oResult !== 32'd63 || lat !== 3) begin
            n_bad++;
            $display("FAIL midreset_restart: got %0d lat %0d expected 63 lat 3",
                     bus.oResult, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res [3];
        int          at  [3];
        logic [31:0] exp_res [3];
        int dcount;
        exp_res[0] = 32'h00123400;  // 0x1234 * 0x0100 unsigned
        exp_res[1] = 32'h40000000;  // -32768 * -32768
        exp_res[2] = 32'hFFFF8001;  // 32767 * -1
        for (int i = 0; i < 3; i++) begin
            res[i] = '0;
            at[i]  = -1;
        end
        dcount = 0;
        @(negedge Clock);
        bus.iSigned = 1'b0; bus.iA = 16'h1234; bus.iB = 16'h0100; bus.iStart = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge Clock);
            #1;
            if (c == 0) begin
                bus.iSigned = 1'b1; bus.iA = 16'h8000; bus.iB = 16'h8000;
            end else if (c == 4) begin
                bus.iSigned = 1'b1; bus.iA = 16'h7FFF; bus.iB = 16'hFFFF;
            end else if (c == 8) begin
                bus.iStart = 1'b0; bus.iSigned = 1'b0; bus.iA = 16'd0; bus.iB = 16'd0;
            end
            @(negedge Clock);
            if (bus.oDone) begin
                if (dcount < 3) begin
                    res[dcount] = bus.oResult;
                    at[dcount]  = c;
                end
                dcount++;
            end
        end
        n_cmp++;
        if (dcount !== 3) begin
            n_bad++;
            $display("FAIL b2b_done_count: got %0d expected 3", dcount);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (res[i] !== exp_res[i] || at[i] !== 4 * i + 3) begin
                n_bad++;
                $display("FAIL b2b_op%0d: got %h at edge %0d expected %h at edge %0d",
                         i, res[i], at[i], exp_res[i], 4 * i + 3);
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned_max();
        test_signed();
        test_zero();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/imul_sign_sequencer.md
Name: imul_sign_sequencer

Overview:
Sequential front/back stage around the team's 16x16 unsigned combinational array multiplier. It accepts signed or unsigned 16-bit operands with a start pulse, and drives operand magnitudes into the array. It waits a fixed number of cycles for the ripple array to settle, captures the 32-bit product, applies two's-complement sign correction and presents a registered result with a one-cycle done pulse.

Parameters:
SETTLE_CYCLES, 2, clock cycles the array output is allowed to settle before capture; legal range 1..15.

Ports:
Clock  input  1  rising-edge clock
Reset  input  1  synchronous, active-high reset
iStart  input  1  start request; sampled only in IDLE
iSigned  input  1  1 = treat iA/iB as two's complement, 0 = unsigned; sampled with iStart
iA  input  16  operand A; sampled with iStart
iB  input  16  operand B; sampled with iStart
oMagA  output  16  registered magnitude of A, wired to the multiplier's iA
oMagB  output  16  registered magnitude of B, wired to the multiplier's iB
iProd  input  32  unsigned product from the multiplier's oR
oResult  output  32  registered final product, held until the next completion
oDone  output  1  one-cycle pulse when oResult updates
oBusy  output  1  high from the cycle after iStart is accepted until oDone

Behaviour:
- Reset (synchronous, priority over everything): state IDLE, oMagA=0, oMagB=0, oResult=0, oDone=0, oBusy=0, wait counter=0, sign flag=0.
- State machine: IDLE -> WAIT -> CAPTURE -> IDLE.
- IDLE, iStart=1 at edge t:
  - Sign flag := iSigned & (iA[15] ^ iB[15]).
  - oMagA := (iSigned & iA[15]) ? -iA mod 2^16 : iA; oMagB likewise.
  - Counter := SETTLE_CYCLES-1; oBusy := 1; go to WAIT.
- IDLE, iStart=0: no change; oDone := 0.
- WAIT: decrement the counter each edge. When the counter is 0, go to CAPTURE. Operand registers are held stable throughout.
- CAPTURE (single cycle):
  - oResult := sign ? (~iProd + 1) mod 2^32 : iProd.
  - oDone := 1; oBusy := 0; go to IDLE.
- Latency: oDone is high in the cycle after edge t+SETTLE_CYCLES+1 (SETTLE_CYCLES=2 gives 3 edges after the start edge). Fixed and data-independent.
- Arithmetic rules:
  - -32768 has magnitude 0x8000, which is valid unsigned.
  - (-32768)*(-32768) = 0x40000000 with no overflow; the full 32-bit result is always exact.
  - A zero product with the sign set yields 0 (negating 0 gives 0).
  - Unsigned mode: oResult = iProd unchanged.
- iStart while oBusy=1: ignored, with no queuing and no effect on the current operation. iStart in the same cycle as oDone (state IDLE): accepted normally, back-to-back.
- oDone is never high for two consecutive cycles.
- Reset mid-operation: abort immediately to reset values; no oDone is produced for the aborted operation.
- Input changes on iA/iB/iSigned after acceptance have no effect.

Optional Feature:
IMUL_ZERO_SKIP_EN
- Defined: if the sampled iA==0 or iB==0 at acceptance, skip WAIT and go directly to a CAPTURE that forces oResult=0. oDone is then high in the cycle after edge t+1. Non-zero operands behave as without the macro.
- Undefined: all operations take the fixed SETTLE_CYCLES+1 latency.

Test Plan:
(The bench instantiates the unsigned array multiplier between oMagA/oMagB and iProd, with SETTLE_CYCLES=2.)
- Unsigned 0xFFFF x 0xFFFF, iSigned=0 -> oResult=0xFFFE0001, oDone pulse exactly 3 edges after the start edge, oBusy high 3 cycles.
- Signed -3 (0xFFFD) x 5 -> oMagA=3, oMagB=5, oResult=0xFFFFFFF1. Signed -32768 x -32768 -> oResult=0x40000000.
- Signed 0 x -7 -> oResult=0x00000000. With IMUL_ZERO_SKIP_EN defined, oDone arrives 1 edge after the start edge.
- iStart pulsed again during WAIT with different operands -> ignored; result matches the first operands; only one oDone.
- Reset asserted during WAIT -> next cycle all outputs 0, no oDone. A new start afterwards (7 x 9 unsigned) -> oResult=63.
- Back-to-back: iStart held high continuously, with operands changed after each acceptance -> one oDone every 4 cycles, each result correct for its sampled operands.
